// File: rtl/mw_add_ctrl_pkg.sv
// rtl/mw_add_ctrl_pkg.sv - shared types and constants for the multi-word adder controller
package mw_add_ctrl_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mw_add_ctrl_add16_cla.sv
// rtl/mw_add_ctrl_add16_cla.sv - 16-bit adder slice, four 4-bit lookahead groups rippled together
module add16_cla
  import mw_add_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] s,
  output logic              cout
);

  // gc[n] is the carry entering group n; gc[4] leaves the slice
  logic [4:0] gc;

  assign gc[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_grp
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a[4*gi +: 4] & b[4*gi +: 4];
    assign p    = a[4*gi +: 4] ^ b[4*gi +: 4];
    assign c[0] = gc[gi];
    // every carry inside the group is a flat function of g, p and the group carry-in
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);

    assign s[4*gi +: 4] = p ^ c[3:0];
    assign gc[gi+1]     = c[4];
  end

  assign cout = gc[4];

endmodule

// File: rtl/mw_add_ctrl.sv
// rtl/mw_add_ctrl.sv - sequences one 16-bit slice over NWORDS words to add or subtract wide operands
module mw_add_ctrl
  import mw_add_ctrl_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op,
  input  logic [WORD_W*NWORDS-1:0] a,
  input  logic [WORD_W*NWORDS-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_e                     state_q, state_d;
  logic [WORD_W*NWORDS-1:0]   a_q, a_d;
  logic [WORD_W*NWORDS-1:0]   b_q, b_d;
  logic                       op_q, op_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       carry_q, carry_d;
  logic [WORD_W-1:0]          sum_q [NWORDS];
  logic [WORD_W-1:0]          sum_d [NWORDS];
  logic                       cout_q, cout_d;
  logic                       ovf_q, ovf_d;

  logic [WORD_W-1:0]          a_w [NWORDS];
  logic [WORD_W-1:0]          b_w [NWORDS];
  logic [WORD_W-1:0]          slice_a;
  logic [WORD_W-1:0]          slice_b;
  logic [WORD_W-1:0]          slice_s;
  logic                       slice_co;
  logic                       last_word;

  for (genvar wi = 0; wi < NWORDS; wi++) begin : g_word
    assign a_w[wi] = a_q[WORD_W*wi +: WORD_W];
    assign b_w[wi] = b_q[WORD_W*wi +: WORD_W];
    assign sum[WORD_W*wi +: WORD_W] = sum_q[wi];
  end

  // subtract is a + ~b + 1; the +1 comes from the carry register loaded with op
  assign slice_a   = a_w[idx_q];
  assign slice_b   = b_w[idx_q] ^ {WORD_W{op_q}};
  assign last_word = (idx_q == LAST_IDX);

  add16_cla u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_co)
  );

  // next-state, datapath updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          carry_d = op;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = slice_s;
        carry_d      = slice_co;
        if (last_word) begin
          // top-word carry ends here; it never feeds back into word 0
          cout_d  = slice_co;
          ovf_d   = (slice_a[WORD_W-1] == slice_b[WORD_W-1]) &&
                    (slice_s[WORD_W-1] != slice_a[WORD_W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        sum_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
    end
  end

  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
